// File: rtl/control_multi_pkg.sv
// Shared constants for the multicycle MIPS control unit: state codes,
// opcodes and datapath select encodings.
package control_multi_pkg;

    localparam logic [3:0] ST_IF    = 4'd0;
    localparam logic [3:0] ST_ID    = 4'd1;
    localparam logic [3:0] ST_MADDR = 4'd2;
    localparam logic [3:0] ST_MRD   = 4'd3;
    localparam logic [3:0] ST_MWB   = 4'd4;
    localparam logic [3:0] ST_MWR   = 4'd5;
    localparam logic [3:0] ST_EXEC  = 4'd6;
    localparam logic [3:0] ST_RCOMP = 4'd7;
    localparam logic [3:0] ST_BEQ   = 4'd8;
    localparam logic [3:0] ST_JMP   = 4'd9;
    localparam logic [3:0] ST_AIEX  = 4'd10;
    localparam logic [3:0] ST_AIWB  = 4'd11;
    localparam logic [3:0] ST_BNE   = 4'd12;

    typedef enum logic [3:0] {
        S_IF    = ST_IF,
        S_ID    = ST_ID,
        S_MADDR = ST_MADDR,
        S_MRD   = ST_MRD,
        S_MWB   = ST_MWB,
        S_MWR   = ST_MWR,
        S_EXEC  = ST_EXEC,
        S_RCOMP = ST_RCOMP,
        S_BEQ   = ST_BEQ,
        S_JMP   = ST_JMP,
        S_AIEX  = ST_AIEX,
        S_AIWB  = ST_AIWB,
        S_BNE   = ST_BNE
    } state_t;

    localparam logic [5:0] R_FORMAT = 6'd0;
    localparam logic [5:0] J        = 6'd2;
    localparam logic [5:0] BEQ      = 6'd4;
    localparam logic [5:0] BNE      = 6'd5;
    localparam logic [5:0] ADDI     = 6'd8;
    localparam logic [5:0] LW       = 6'd35;
    localparam logic [5:0] SW       = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == R_FORMAT) || (op == J) || (op == BEQ) || (op == BNE) ||
               (op == ADDI) || (op == LW) || (op == SW);
    endfunction

endpackage

// File: rtl/control_multi_outdec.sv
// Combinational output decode: current state plus memory-ready gating,
// with all write enables and strobes suppressed while reset is held.
module control_multi_outdec
    import control_multi_pkg::*;
(
    input  state_t     state,
    input  logic       mem_rdy,
    input  logic       reset,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource
);

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        ALUOp         = ALUOP_ADD;
        PCSource      = PCSRC_ALU;

        case (state)
            S_IF: begin
                // PC/IR load only on the completing cycle so a stalled fetch
                // never advances the PC twice.
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
            end
            S_ID: begin
                ALUSrcB = SRCB_BRANCH;
            end
            S_MADDR, S_AIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RCOMP: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_AIWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCSource    = PCSRC_ALUOUT;
                PCWriteCond = 1'b1;
            end
            S_BNE: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALUOP_SUB;
                PCSource      = PCSRC_ALUOUT;
                PCWriteCondNE = 1'b1;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase

        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            PCWriteCondNE = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
        end
    end

endmodule

// File: rtl/control_multi.sv
// Multicycle MIPS control unit: state register and next-state logic, with
// a memory-ready handshake that stalls fetch and data accesses.
//
// state | meaning
// ------+----------------------------------------------
// IF    | fetch instruction, PC+4 (waits on mem_ready)
// ID    | decode, branch target into ALUOut
// MADDR | lw/sw effective address
// MRD   | data read (waits on mem_ready)
// MWB   | load write-back from MDR
// MWR   | data write (waits on mem_ready)
// EXEC  | R-format ALU operation
// RCOMP | R-format write-back to rd
// BEQ   | branch if equal
// JMP   | jump
// AIEX  | addi: A + signext
// AIWB  | addi write-back to rt
// BNE   | branch if not equal
module control_multi
    import control_multi_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;
    logic   illegal_d;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = S_IF;
        illegal_d = 1'b0;
        case (state_q)
            S_IF:    state_d = mem_rdy ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    R_FORMAT: state_d = S_EXEC;
                    LW, SW:   state_d = S_MADDR;
                    BEQ:      state_d = S_BEQ;
                    BNE:      state_d = S_BNE;
                    J:        state_d = S_JMP;
                    ADDI:     state_d = S_AIEX;
                    default: begin
                        state_d   = S_IF;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // Opcode can only change here if IR was disturbed; fall back to fetch.
            S_MADDR: begin
                if (opcode == LW)      state_d = S_MRD;
                else if (opcode == SW) state_d = S_MWR;
                else                   state_d = S_IF;
            end
            S_MRD:   state_d = mem_rdy ? S_MWB : S_MRD;
            S_MWR:   state_d = mem_rdy ? S_IF : S_MWR;
            S_EXEC:  state_d = S_RCOMP;
            S_AIEX:  state_d = S_AIWB;
            default: state_d = S_IF;
        endcase
    end

    assign illegal_op = illegal_d & ~reset;
    assign state      = state_q;

    control_multi_outdec u_outdec (
        .state         (state_q),
        .mem_rdy       (mem_rdy),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .PCSource      (PCSource)
    );

endmodule
